if_fetch_unit: RTL



---
 rtl/mips_pkg.sv | 26 ++
 rtl/if_fetch_unit_if.sv | 27 ++
 rtl/if_fetch_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: bubble encoding, PC step, FSM states.
// Pure declarations, no logic, no latency.
// Not applicable to backpressure; consumers apply their own handshakes.
package mips_pkg;

  // sll $0,$0,0 encodes as all zeros and is the canonical pipeline bubble
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Sequential fetch advances one 32-bit word
  localparam logic [31:0] PC_STEP = 32'd4;

  // REQ  : request outstanding at pc, waiting for memory
  // DRAIN: redirect pending, finishing the request already on the bus
  // HOLD : fetched word parked in the buffer while IF/ID is stalled
  typedef enum logic [1:0] {
    REQ   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // Sequential successor address; wraps silently at 2^32
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request bus between the fetch unit and instruction memory.
// Combinational bundle, no latency of its own.
// req/ready handshake: addr held while req=1 and ready=0; ready may rise in the request cycle.
interface if_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  // Fetch unit side: issues the request, consumes the response
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  // Memory side: observes the request, returns data with ready
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: owns the PC, fetches over the imem bus, feeds the IF/ID register.
// Latency: IF_ID_Inst appears in the cycle imem_ready rises (zero-bubble on same-cycle ready).
// Backpressure: hazard parks a returned word in a one-entry buffer and stops requesting until released.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hazard,
  input  logic                    branch_taken,
  input  logic [31:0]             branch_target,
  if_fetch_unit_if.master         imem,
  output logic [31:0]             IF_ID_Inst,
  output logic [31:0]             IF_ID_NewPC
);

  import mips_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_inst_q, buf_inst_d;
  logic [31:0]  buf_newpc_q, buf_newpc_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic [31:0]  pc_plus4;

  assign pc_plus4 = next_pc(pc_q);

  // The address bus always reflects pc; pc only moves when a request completes
  // or while no request is outstanding, so the address is stable mid-request.
  assign imem.imem_addr = pc_q;

  // Next-state, PC update and IF/ID drive; priority is reset > branch > hazard > advance
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    buf_inst_d      = buf_inst_q;
    buf_newpc_d     = buf_newpc_q;
    redir_pc_d      = redir_pc_q;
    imem.imem_req   = 1'b1;
    IF_ID_Inst      = NOP_INST;
    IF_ID_NewPC     = pc_plus4;

    case (state_q)
      REQ: begin
        if (imem.imem_ready) begin
          if (branch_taken) begin
            // Wrong-path word: drop it and restart at the target
            pc_d = branch_target;
          end else if (!hazard) begin
            IF_ID_Inst  = imem.imem_rdata;
            IF_ID_NewPC = pc_plus4;
            pc_d        = pc_plus4;
          end else begin
            // IF/ID is frozen: park the word so it is presented exactly once later
            buf_inst_d  = imem.imem_rdata;
            buf_newpc_d = pc_plus4;
            pc_d        = pc_plus4;
            state_d     = HOLD;
          end
        end else if (branch_taken) begin
          // Cannot retarget a live request; remember the target and let it finish
          redir_pc_d = branch_target;
          state_d    = DRAIN;
        end
      end

      DRAIN: begin
        if (imem.imem_ready) begin
          // Youngest redirect wins, including one arriving with the final ready
          pc_d    = branch_taken ? branch_target : redir_pc_q;
          state_d = REQ;
        end else if (branch_taken) begin
          redir_pc_d = branch_target;
        end
      end

      HOLD: begin
        imem.imem_req = 1'b0;
        if (branch_taken) begin
          // Buffered word is on the wrong path; pc already points past it
          pc_d    = branch_target;
          state_d = REQ;
        end else begin
          IF_ID_Inst  = buf_inst_q;
          IF_ID_NewPC = buf_newpc_q;
          if (!hazard) begin
            // IF/ID takes the buffer on this edge; resume at the following word
            state_d = REQ;
          end
        end
      end

      default: begin
        state_d = REQ;
      end
    endcase

    // Reset abandons any transaction; a same-cycle ready must not reach IF/ID
    if (reset) begin
      imem.imem_req = 1'b1;
      IF_ID_Inst    = NOP_INST;
      IF_ID_NewPC   = pc_plus4;
    end
  end

  // State, PC and buffer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      buf_inst_q  <= 32'h0000_0000;
      buf_newpc_q <= 32'h0000_0000;
      redir_pc_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_inst_q  <= buf_inst_d;
      buf_newpc_q <= buf_newpc_d;
      redir_pc_q  <= redir_pc_d;
    end
  end

endmodule
